// File: rtl/fec_coded_encoder.sv
// rtl/fec_coded_encoder.sv - LE Coded PHY FEC: rate-1/2 convolutional encoder, trellis tail, S=8 mapper
// Sits on the 1-bit TX stream between whitener/CRC and modulator.
module fec_coded_encoder #(
  parameter int           K        = 4,
  parameter logic [K-1:0] G0       = 4'b1111,
  parameter logic [K-1:0] G1       = 4'b1011,
  parameter bit           TAIL_EN  = 1'b1,
  parameter logic [3:0]   PAT_ZERO = 4'b0011
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       restart,
  input  logic       bypass,
  input  logic [1:0] coding_indicator,
  input  logic       input_tdata,
  input  logic       input_tvalid,
  output logic       input_tready,
  input  logic       input_tlast,
  output logic       output_tdata,
  output logic       output_tvalid,
  input  logic       output_tready,
  output logic       output_tlast
);

  localparam int TW = $clog2(K) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [K-2:0]    r_sr;
  logic [7:0]      r_buf;
  logic [3:0]      r_cnt;
  logic            r_last;
  logic            r_s8;
  logic [TW-1:0]   r_tail_cnt;

  logic            w_can_load;
  logic            w_drain;
  logic            w_in_ready;
  logic            w_load;
  logic            w_bit;
  logic            w_final;
  logic            w_latch;
  logic            w_s8;
  logic [K-1:0]    w_vec;
  logic            w_a0;
  logic            w_a1;
  logic [7:0]      w_grp;
  logic [3:0]      w_grp_cnt;

  function automatic logic [3:0] pat(input logic b);
    return b ? ~PAT_ZERO : PAT_ZERO;
  endfunction

  // Refill is allowed in the same cycle the last buffered bit drains.
  assign w_can_load = (r_cnt == 4'd0) || ((r_cnt == 4'd1) && output_tready);
  assign w_drain    = (r_cnt != 4'd0) && output_tready && !bypass;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_bit       = 1'b0;
    w_final     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE, S_DATA: begin
        w_in_ready = w_can_load;
        if (!bypass && input_tvalid && w_can_load) begin
          w_load  = 1'b1;
          w_bit   = input_tdata;
          w_latch = (r_state == S_IDLE);
          if (input_tlast) begin
            w_state_nxt = TAIL_EN ? S_TAIL : S_DONE;
            w_final     = !TAIL_EN;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_TAIL: begin
        if (w_can_load) begin
          w_load = 1'b1;
          if (r_tail_cnt == TW'(K - 2)) begin
            w_state_nxt = S_DONE;
            w_final     = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_s8      = w_latch ? (coding_indicator == 2'd0) : r_s8;
  assign w_vec     = {w_bit, r_sr};
  assign w_a0      = ^(w_vec & G0);
  assign w_a1      = ^(w_vec & G1);
  assign w_grp     = w_s8 ? {pat(w_a0), pat(w_a1)} : {w_a0, w_a1, 6'b0};
  assign w_grp_cnt = w_s8 ? 4'd8 : 4'd2;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_s8       <= 1'b0;
      r_tail_cnt <= '0;
    end else if (restart) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_s8       <= 1'b0;
      r_tail_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_buf  <= w_grp;
        r_cnt  <= w_grp_cnt;
        r_last <= w_final;
        r_sr   <= w_vec[K-1:1];
      end else if (w_drain) begin
        r_buf <= {r_buf[6:0], 1'b0};
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_latch) r_s8 <= w_s8;
      if (r_state != S_TAIL)  r_tail_cnt <= '0;
      else if (w_load)        r_tail_cnt <= r_tail_cnt + TW'(1);
    end
  end

  assign input_tready  = !areset && (bypass ? output_tready : w_in_ready);
  assign output_tvalid = !areset && (bypass ? input_tvalid : (r_cnt != 4'd0));
  assign output_tdata  = !areset && (bypass ? input_tdata  : r_buf[7]);
  assign output_tlast  = !areset && (bypass ? input_tlast  : (r_last && (r_cnt == 4'd1)));

endmodule

// File: tb/tb_fec_coded_encoder.sv
// tb/tb_fec_coded_encoder.sv - scoreboard bench for fec_coded_encoder
module tb_fec_coded_encoder;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       restart = 1'b0;
  logic       bypass = 1'b0;
  logic [1:0] coding_indicator = 2'd1;
  logic       input_tdata = 1'b0;
  logic       input_tvalid = 1'b0;
  logic       input_tready;
  logic       input_tlast = 1'b0;
  logic       output_tdata;
  logic       output_tvalid;
  logic       output_tready;
  logic       output_tlast;

  logic       rand_en = 1'b0;
  logic       rnd_bit = 1'b1;
  logic       tready_force = 1'b1;
  assign output_tready = rand_en ? rnd_bit : tready_force;

  int checks = 0;
  int failures = 0;
  logic [1:0] sb[$];

  fec_coded_encoder dut (
    .aclk(aclk), .areset(areset), .restart(restart), .bypass(bypass),
    .coding_indicator(coding_indicator),
    .input_tdata(input_tdata), .input_tvalid(input_tvalid),
    .input_tready(input_tready), .input_tlast(input_tlast),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid),
    .output_tready(output_tready), .output_tlast(output_tlast)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {data,last} per output transfer.
  always @(negedge aclk) begin
    if (!areset && !bypass && output_tvalid && output_tready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0b%0b expected=none", output_tdata, output_tlast);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        check("out_bit_last", {30'd0, output_tdata, output_tlast}, {30'd0, e});
      end
    end
  end

  task automatic push_seq(input logic [31:0] bits, input int n, input logic mark_last);
    for (int i = n - 1; i >= 0; i--)
      sb.push_back({bits[i], (mark_last && i == 0)});
  endtask

  task automatic send_bit(input logic d, input logic last);
    int n;
    @(posedge aclk); #1;
    input_tvalid = 1'b1; input_tdata = d; input_tlast = last;
    n = 0;
    forever begin
      @(negedge aclk);
      if (input_tready) break;
      n++;
      if (n > 1000) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge aclk); #1;
    input_tvalid = 1'b0; input_tlast = 1'b0; input_tdata = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 || output_tvalid) begin
      @(negedge aclk);
      n++;
      if (n > 3000) begin
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
        break;
      end
    end
  endtask

  task automatic wait_sb_empty();
    int n;
    n = 0;
    do begin
      @(posedge aclk); #2;
      n++;
    end while (sb.size() != 0 && n < 1000);
    check("partial_emit", sb.size(), 32'd0);
  endtask

  logic [3:0] bvec [4];
  initial begin
    bvec[0] = 4'b1101; bvec[1] = 4'b1110; bvec[2] = 4'b0011; bvec[3] = 4'b1011;

    // Reset state
    #2;
    check("rst_tvalid", {31'd0, output_tvalid}, 32'd0);
    check("rst_tready", {31'd0, input_tready}, 32'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("idle_tready", {31'd0, input_tready}, 32'd1);

    // S2 single bit 1
    coding_indicator = 2'd1;
    push_seq(32'b11101111, 8, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_drain();
    repeat (2) @(negedge aclk);
    check("s2_tready_after", {31'd0, input_tready}, 32'd1);

    // S8 single bit 1, indicator changed mid-packet must be ignored
    coding_indicator = 2'd0;
    push_seq(32'hCCC3CCCC, 32, 1'b1);
    send_bit(1'b1, 1'b1);
    coding_indicator = 2'd1;
    @(negedge aclk);
    check("s8_tready_busy", {31'd0, input_tready}, 32'd0);
    wait_drain();

    // S8 single bit 0
    coding_indicator = 2'd0;
    push_seq(32'h33333333, 32, 1'b1);
    send_bit(1'b0, 1'b1);
    wait_drain();

    // S2 packet 1,0,1,1: tready high, then random backpressure
    coding_indicator = 2'd2;
    for (int r = 0; r < 2; r++) begin
      rand_en = (r == 1);
      push_seq(32'b11100010010011, 14, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      wait_drain();
    end
    rand_en = 1'b0;
    tready_force = 1'b1;
    repeat (2) @(negedge aclk);

    // restart after 3 of 8 S8 bits emitted
    coding_indicator = 2'd0;
    push_seq(32'b110, 3, 1'b0);
    send_bit(1'b1, 1'b1);
    wait_sb_empty();
    tready_force = 1'b0;
    restart = 1'b1;
    @(posedge aclk); #1;
    restart = 1'b0;
    check("restart_tvalid", {31'd0, output_tvalid}, 32'd0);
    check("restart_tlast", {31'd0, output_tlast}, 32'd0);
    tready_force = 1'b1;
    @(negedge aclk);
    check("restart_tready", {31'd0, input_tready}, 32'd1);
    coding_indicator = 2'd1;
    push_seq(32'b11101111, 8, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_drain();
    repeat (2) @(negedge aclk);

    // areset mid-stream
    push_seq(32'b11, 2, 1'b0);
    send_bit(1'b1, 1'b0);
    wait_sb_empty();
    tready_force = 1'b0;
    input_tvalid = 1'b1;
    areset = 1'b1;
    #1;
    check("arst_tvalid", {31'd0, output_tvalid}, 32'd0);
    check("arst_tdata", {31'd0, output_tdata}, 32'd0);
    check("arst_tlast", {31'd0, output_tlast}, 32'd0);
    check("arst_tready", {31'd0, input_tready}, 32'd0);
    input_tvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    tready_force = 1'b1;
    @(negedge aclk);
    check("arst_rel_tready", {31'd0, input_tready}, 32'd1);
    push_seq(32'b11101111, 8, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_drain();
    repeat (2) @(negedge aclk);

    // bypass passthrough
    @(posedge aclk); #1;
    bypass = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      input_tvalid = bvec[i][3]; input_tdata = bvec[i][2];
      input_tlast = bvec[i][1]; tready_force = bvec[i][0];
      @(negedge aclk);
      check("byp_tvalid", {31'd0, output_tvalid}, {31'd0, bvec[i][3]});
      check("byp_tdata", {31'd0, output_tdata}, {31'd0, bvec[i][2]});
      check("byp_tlast", {31'd0, output_tlast}, {31'd0, bvec[i][1]});
      check("byp_tready", {31'd0, input_tready}, {31'd0, bvec[i][0]});
    end
    @(posedge aclk); #1;
    input_tvalid = 1'b0; input_tdata = 1'b0; input_tlast = 1'b0;
    tready_force = 1'b1;
    bypass = 1'b0;
    push_seq(32'b11101111, 8, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_drain();
    repeat (3) @(negedge aclk);
    check("sb_final_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
